// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// Fetch stage that sits directly in front of a combinational instruction
// memory. It holds the program counter, drives the word-aligned fetch address,
// and captures each returned word together with its PC into a small circular
// prefetch queue. Decode drains the queue over a valid/ready handshake. A
// branch/jump redirect flushes the queue and restarts fetch at the target.
//
// Optional feature (compile-time macro IFETCH_HALT_DETECT_EN):
//   A fetched all-zero word (unprogrammed memory) is still enqueued, but fetch
//   then parks in HALT with the pc at that address + 4. Only a redirect or
//   reset leaves HALT. Without the macro, zero is an ordinary instruction and
//   halted is tied to 0.
//
// Parameters:
//   RESET_PC     pc after reset (bits [1:0] ignored)
//   QUEUE_DEPTH  prefetch queue entries, 2 or 4
//   CNT_W        width of queue_count, must hold QUEUE_DEPTH
//
// Ports:
//   clk             sole clock, rising edge
//   reset           asynchronous, active-high reset
//   imem_addr       fetch address (always word aligned, equals pc)
//   imem_instr      instruction word for imem_addr, same cycle
//   redirect_valid  single-cycle taken branch/jump pulse from execute
//   redirect_pc     redirect target (bits [1:0] dropped)
//   if_valid        queue head holds a valid entry
//   if_instr        instruction at queue head (registered)
//   if_pc           PC of instruction at queue head (registered)
//   id_ready        decode accepts the head this cycle
//   queue_count     registered queue occupancy
//   halted          fetch parked by halt detection
// -----------------------------------------------------------------------------
module instruction_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2,
  parameter int          CNT_W       = 3
) (
  input  logic             clk,
  input  logic             reset,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_instr,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic             if_valid,
  output logic [31:0]      if_instr,
  output logic [31:0]      if_pc,
  input  logic             id_ready,
  output logic [CNT_W-1:0] queue_count,
  output logic             halted
);

  localparam int               PTR_W    = (QUEUE_DEPTH > 2) ? 2 : 1;
  localparam logic [31:0]      PC_RST   = {RESET_PC[31:2], 2'b00};
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(QUEUE_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(QUEUE_DEPTH - 1);

`ifdef IFETCH_HALT_DETECT_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_RUN} state_t;
`endif

  state_t           state, state_nxt;
  logic [31:0]      pc, pc_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic [PTR_W-1:0] head, tail;
  logic [31:0]      q_pc    [QUEUE_DEPTH];
  logic [31:0]      q_instr [QUEUE_DEPTH];
  logic             pop, push;

  // Circular pointer advance; wraps at QUEUE_DEPTH.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Decode consumes the head whenever it is valid and ready, even on a
  // redirect cycle.
  assign pop = if_valid && id_ready;

  // ---------------------------------------------------------------------------
  // Next-state / push decision
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_nxt = state;
    push      = 1'b0;

    case (state)
      S_IDLE: state_nxt = S_RUN;
      S_RUN: begin
        // A simultaneous pop frees a slot, so a full queue can still accept.
        push = (count < DEPTH_C) || pop;
`ifdef IFETCH_HALT_DETECT_EN
        if (push && (imem_instr == 32'h0000_0000)) state_nxt = S_HALT;
`endif
      end
`ifdef IFETCH_HALT_DETECT_EN
      S_HALT: state_nxt = S_HALT;
`endif
      default: state_nxt = S_IDLE;
    endcase

    // Redirect wins over everything: no push, resume fetching at the target.
    if (redirect_valid) begin
      push      = 1'b0;
      state_nxt = S_RUN;
    end
  end

  always_comb begin
    pc_nxt    = pc;
    count_nxt = count;
    if (redirect_valid) begin
      pc_nxt    = {redirect_pc[31:2], 2'b00};
      count_nxt = '0;
    end else begin
      if (push) pc_nxt = pc + 32'd4;  // wraps modulo 2^32
      case ({push, pop})
        2'b10:   count_nxt = count + CNT_W'(1);
        2'b01:   count_nxt = count - CNT_W'(1);
        default: count_nxt = count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State, pc and queue registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      pc    <= PC_RST;
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      count <= count_nxt;
      if (redirect_valid) begin
        head <= '0;
        tail <= '0;
      end else begin
        if (push) tail <= ptr_inc(tail);
        if (pop)  head <= ptr_inc(head);
      end
    end
  end

  // NOTE: the queue storage is tiny and drives if_instr/if_pc directly, so it
  // is reset to keep those outputs at a defined value out of reset; a large
  // RAM would normally be left unreset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        q_pc[i]    <= '0;
        q_instr[i] <= '0;
      end
    end else if (push) begin
      q_pc[tail]    <= pc;
      q_instr[tail] <= imem_instr;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all from registers, never a pass-through of imem_instr.
  // ---------------------------------------------------------------------------
  assign imem_addr   = pc;
  assign if_valid    = (count != '0);
  assign if_instr    = q_instr[head];
  assign if_pc       = q_pc[head];
  assign queue_count = count;
`ifdef IFETCH_HALT_DETECT_EN
  assign halted      = (state == S_HALT);
`else
  assign halted      = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
//
// Scoreboard bench for instruction_fetch. Two instances share clk/reset:
//   dut  : RESET_PC = 0, QUEUE_DEPTH = 2 (main traffic, stalls, redirects,
//          halt detection when IFETCH_HALT_DETECT_EN is defined)
//   dut2 : RESET_PC = 0xFFFFFFFA, QUEUE_DEPTH = 4 (reset pc alignment, pc
//          wrap, deep queue fill)
// Stimulus pushes the entries each instance is expected to hand to decode;
// a monitor per instance pops and compares on every handshake.
// Memory word at address a is ((a >> 2) + 1) * 0x11111111 (low 32 bits),
// optionally 0 at address 0x0C for the halt test.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        zero_at_c;

  logic [31:0] imem_addr, imem_instr, redirect_pc, if_instr, if_pc;
  logic        redirect_valid, if_valid, id_ready, halted;
  logic [2:0]  queue_count;

  logic [31:0] imem_addr2, imem_instr2, if_instr2, if_pc2;
  logic        if_valid2, id_ready2, halted2;
  logic [2:0]  queue_count2;

  entry_t exp_q[$];
  entry_t exp_q2[$];
  int     total = 0;
  int     bad   = 0;

  always #5 clk = ~clk;

  // Combinational instruction memories.
  always_comb begin
    imem_instr = ({2'b00, imem_addr[31:2]} + 32'd1) * 32'h1111_1111;
    if (zero_at_c && imem_addr == 32'h0000_000C) imem_instr = 32'h0;
  end
  always_comb imem_instr2 = ({2'b00, imem_addr2[31:2]} + 32'd1) * 32'h1111_1111;

  instruction_fetch #(.RESET_PC(32'h0000_0000), .QUEUE_DEPTH(2), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_ready(id_ready), .queue_count(queue_count), .halted(halted));

  instruction_fetch #(.RESET_PC(32'hFFFF_FFFA), .QUEUE_DEPTH(4), .CNT_W(3)) dut2 (
    .clk(clk), .reset(reset), .imem_addr(imem_addr2), .imem_instr(imem_instr2),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .if_valid(if_valid2), .if_instr(if_instr2), .if_pc(if_pc2),
    .id_ready(id_ready2), .queue_count(queue_count2), .halted(halted2));

  function automatic logic [31:0] mem_word(input logic [31:0] a, input logic zc);
    if (zc && a == 32'h0000_000C) return 32'h0;
    return ({2'b00, a[31:2]} + 32'd1) * 32'h1111_1111;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_q.push_back('{pc: pc, instr: mem_word(pc, zero_at_c)});
  endtask

  task automatic push_exp2(input logic [31:0] pc);
    exp_q2.push_back('{pc: pc, instr: mem_word(pc, 1'b0)});
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Monitors: compare each handshake against the scoreboard head.
  always @(negedge clk) begin
    if (if_valid && id_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_pop: got pc 0x%08h, none expected", if_pc);
      end else begin
        entry_t e;
        e = exp_q.pop_front();
        check("head_pc", if_pc, e.pc);
        check("head_instr", if_instr, e.instr);
      end
    end
  end

  always @(negedge clk) begin
    if (if_valid2 && id_ready2) begin
      if (exp_q2.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_pop2: got pc 0x%08h, none expected", if_pc2);
      end else begin
        entry_t e;
        e = exp_q2.pop_front();
        check("dut2_pc", if_pc2, e.pc);
        check("dut2_instr", if_instr2, e.instr);
      end
    end
  end

  // Safety net: the bench never waits on DUT events, but never hang anyway.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; zero_at_c = 1'b0; id_ready = 1'b1; id_ready2 = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    cycle(); cycle();

    // ---- reset values ----
    check("rst_valid",  32'(if_valid), 32'd0);
    check("rst_count",  32'(queue_count), 32'd0);
    check("rst_addr",   imem_addr, 32'h0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_addr2",  imem_addr2, 32'hFFFF_FFF8);
    check("rst_valid2", 32'(if_valid2), 32'd0);

    // ---- phase 1: streaming with id_ready = 1; dut2 fills then wraps ----
    for (int i = 0; i < 6; i++) push_exp(32'(i * 4));
    push_exp2(32'hFFFF_FFF8); push_exp2(32'hFFFF_FFFC); push_exp2(32'h0);
    reset = 1'b0;
    cycle();                                   // IDLE -> RUN
    check("idle_valid", 32'(if_valid), 32'd0);
    check("idle_addr",  imem_addr, 32'h0);
    cycle();                                   // first push
    check("first_valid", 32'(if_valid), 32'd1);
    check("first_count", 32'(queue_count), 32'd1);
    for (int i = 3; i <= 8; i++) begin
      cycle();
      check("stream_count", 32'(queue_count), 32'd1);
      if (i == 5) begin
        check("dut2_full_count", 32'(queue_count2), 32'd4);
        check("dut2_wrap_addr",  imem_addr2, 32'h0000_0008);
        id_ready2 = 1'b1;
      end
    end

    // ---- reset mid-operation ----
    reset = 1'b1;
    #1;
    check("midrst_valid", 32'(if_valid), 32'd0);
    check("midrst_count", 32'(queue_count), 32'd0);
    check("midrst_addr",  imem_addr, 32'h0);
    check("midrst_count2", 32'(queue_count2), 32'd0);
    check("drain1",  32'(exp_q.size()), 32'd0);
    check("drain1b", 32'(exp_q2.size()), 32'd0);

    // ---- phase 2: stall, redirect on full queue, redirect with pop ----
    id_ready = 1'b0; id_ready2 = 1'b0;
    push_exp(32'h0); push_exp(32'h4); push_exp(32'h8);
    push_exp(32'h100); push_exp(32'h200); push_exp(32'h204);
    cycle();
    reset = 1'b0;
    cycle(); cycle(); cycle();
    check("stall_count", 32'(queue_count), 32'd2);
    check("stall_addr",  imem_addr, 32'h8);
    cycle(); cycle(); cycle();
    check("hold_count", 32'(queue_count), 32'd2);
    check("hold_addr",  imem_addr, 32'h8);
    check("hold_pc",    if_pc, 32'h0);
    check("hold_instr", if_instr, 32'h1111_1111);
    id_ready = 1'b1;
    cycle(); cycle(); cycle();
    check("full_stream_count", 32'(queue_count), 32'd2);

    id_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    cycle();
    redirect_valid = 1'b0;
    check("redir_count", 32'(queue_count), 32'd0);
    check("redir_valid", 32'(if_valid), 32'd0);
    check("redir_addr",  imem_addr, 32'h0000_0100);
    cycle();
    check("redir_head_valid", 32'(if_valid), 32'd1);
    check("redir_head_pc",    if_pc, 32'h0000_0100);
    check("redir_head_instr", if_instr, mem_word(32'h100, 1'b0));
    cycle();
    check("refill_count", 32'(queue_count), 32'd2);

    id_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    cycle();
    redirect_valid = 1'b0;
    check("redirpop_count", 32'(queue_count), 32'd0);
    check("redirpop_valid", 32'(if_valid), 32'd0);
    check("redirpop_addr",  imem_addr, 32'h0000_0200);
    cycle(); cycle(); cycle();
    id_ready = 1'b0;
    check("drain2", 32'(exp_q.size()), 32'd0);

`ifdef IFETCH_HALT_DETECT_EN
    // ---- phase 3: halt on zero word, redirect out, reset while halted ----
    reset = 1'b1; zero_at_c = 1'b1; id_ready = 1'b1;
    cycle();
    push_exp(32'h0); push_exp(32'h4); push_exp(32'h8); push_exp(32'hC);
    push_exp(32'h0); push_exp(32'h4); push_exp(32'h8); push_exp(32'hC);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) cycle();
    check("halt_flag",  32'(halted), 32'd1);
    check("halt_count", 32'(queue_count), 32'd0);
    check("halt_addr",  imem_addr, 32'h10);
    cycle(); cycle();
    check("halt_nopush", 32'(queue_count), 32'd0);
    check("halt_hold",   imem_addr, 32'h10);
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    cycle();
    redirect_valid = 1'b0;
    check("unhalt_flag", 32'(halted), 32'd0);
    check("unhalt_addr", imem_addr, 32'h0);
    for (int i = 0; i < 5; i++) cycle();
    check("rehalt_flag", 32'(halted), 32'd1);
    reset = 1'b1;
    #1;
    check("halt_rst_flag",  32'(halted), 32'd0);
    check("halt_rst_valid", 32'(if_valid), 32'd0);
    check("halt_rst_count", 32'(queue_count), 32'd0);
    check("halt_rst_addr",  imem_addr, 32'h0);
    check("drain3", 32'(exp_q.size()), 32'd0);
    zero_at_c = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
